uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin arbiter and configuration front-end for the shared UART transmitter. It accepts single-byte send requests from up to `N_REQ` independent requesters, such as the CPU store path and a debug/trace source. It issues one byte at a time to the transmitter's `uart_tx_en`/`uart_tx_data` interface and tracks `uart_tx_busy` until the frame completes. It also owns the transmitter's `CYCLES_PER_BIT` value and applies baud changes only between frames.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, range 2..8.
- `RESET_CPB`, default 104: reset value of `cycles_per_bit`.

Ports:
- `clk`, input, 1: clock.
- `resetn`, input, 1: synchronous reset, active-low.
- `req_valid`, input, `N_REQ`: per-requester send request. Once asserted, it is held with its data stable until the matching `req_ready` pulse.
- `req_data`, input, `8*N_REQ`: request bytes; requester i uses bits [8i+7:8i].
- `req_ready`, output, `N_REQ`: one-cycle acceptance pulse, one-hot or zero.
- `cfg_wr`, input, 1: one-cycle write strobe for the bit-period value.
- `cfg_cpb`, input, 16: new cycles-per-bit value.
- `cfg_pending`, output, 1: a written value is waiting to be applied.
- `tx_en`, output, 1: drives the transmitter's `uart_tx_en`.
- `tx_data`, output, 8: drives the transmitter's `uart_tx_data`.
- `tx_busy`, input, 1: from the transmitter's `uart_tx_busy`.
- `cycles_per_bit`, output, 16: drives the transmitter's `CYCLES_PER_BIT`.
- `grant_id`, output, `$clog2(N_REQ)`: index of the most recently granted requester.
- `active`, output, 1: high whenever the FSM is not in IDLE.

## Operation
FSM states, all transitions registered:
- **IDLE**
  - If `cfg_pending`: apply the pending config and stay in IDLE. Arbitration is deferred one cycle.
  - Else, if any `req_valid` is high: pick a winner and go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE** (exactly 1 cycle)
  - `tx_en` = 1.
  - `tx_data` = the winner's byte, latched on entry.
  - `req_ready[winner]` = 1.
  - Always go to WAIT_BUSY.
- **WAIT_BUSY**: go to WAIT_DONE when `tx_busy` = 1. There is no timeout; the transmitter raises busy the cycle after `tx_en`.
- **WAIT_DONE**: go to IDLE when `tx_busy` = 0.
- Encodings 4..7 are illegal and return to IDLE.

Arbitration:
- Round-robin over `req_valid`. The search starts at `last_grant+1` modulo `N_REQ` and wraps.
- `last_grant` (visible as `grant_id`) is updated on entry to ISSUE. It resets to `N_REQ-1`, so requester 0 has first priority.
- A requester that drops `req_valid` before being granted is simply skipped. Requesters must not do this once `req_ready` is due.

Data:
- `tx_data` is a register loaded on IDLE→ISSUE and held until the next grant.
- `req_data` is sampled only on the IDLE→ISSUE edge.

Configuration:
- `cfg_wr` with `cfg_cpb` != 0 loads a pending register and sets `cfg_pending`.
- A write while pending overwrites the held value (last write wins).
- `cfg_wr` with `cfg_cpb` = 0 is ignored.
- The pending value is copied to `cycles_per_bit` only in IDLE, and `cfg_pending` clears in the same cycle. `cycles_per_bit` therefore never changes between ISSUE and the return to IDLE.
- `cfg_wr` in the same cycle as the IDLE apply cycle: the new value replaces the pending one and stays pending for the next IDLE cycle.

Reset (`resetn` = 0 at a clk edge, in any state including mid-frame):
- FSM goes to IDLE; `tx_en` = 0, `tx_data` = 0, `req_ready` = 0.
- `cycles_per_bit` = `RESET_CPB`; `cfg_pending` = 0, and any pending value is discarded.
- `grant_id` = `N_REQ-1`; `active` = 0.
- The transmitter shares `resetn`, so no in-flight frame survives.

## Timing
- A request first seen in IDLE at edge k produces `tx_en`/`req_ready` high during cycle k+1.
- `tx_busy` is expected high at cycle k+2.
- `tx_busy` first low at cycle m gives IDLE at m+1. The earliest next `tx_en` is m+2, so there are at least 2 idle cycles between frames.
- If a config is pending, the next `tx_en` is delayed by 1 additional cycle.
- `tx_en` is never high for more than 1 consecutive cycle, and never high while `tx_busy` = 1.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Reset values**: hold reset, then release → `cycles_per_bit` = 104, `tx_en` = 0, `grant_id` = 3, `active` = 0.
- **Single request**: `req_valid[2]` with data 0x5A, using a transmitter model whose busy lasts 20 cycles → one `tx_en` pulse with `tx_data` = 0x5A and `req_ready` = 4'b0100 in the same cycle, `grant_id` = 2, then IDLE 1 cycle after busy falls.
- **Round-robin fairness**: all four `req_valid` held continuously with distinct bytes → grant order 0,1,2,3,0,… with exactly one `req_ready` per frame and no `tx_en` during busy.
- **Wrap-around**: last grant = 3, requests on {1,3} → 1 is granted next, then 3.
- **Config deferral**: `cfg_wr` with value 52 during WAIT_DONE → `cycles_per_bit` stays 104 until IDLE. It becomes 52 one cycle before the next `tx_en`. A `cfg_cpb` = 0 write leaves the value unchanged.
- **Mid-frame reset**: `resetn` low during WAIT_DONE with a config pending → all reset values restored, pending value discarded, and the held request is re-arbitrated from requester 0 after release.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin arbiter and configuration front-end for the shared UART
// transmitter. Up to N_REQ requesters post single bytes; one byte at a time is
// handed to the transmitter through tx_en/tx_data, and the arbiter follows
// tx_busy until that frame completes. The arbiter also owns the transmitter's
// bit period (cycles_per_bit) and only changes it between frames.
//
// State table
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   IDLE      | no frame in flight; apply a pending bit period or arbitrate
//   ISSUE     | tx_en and req_ready[winner] high for exactly this cycle
//   WAIT_BUSY | waiting for the transmitter to raise tx_busy
//   WAIT_DONE | frame on the wire; waiting for tx_busy to fall
//   (4..7)    | illegal encodings, recover to IDLE
//
// Ports
//   clk            clock
//   resetn         synchronous reset, active low
//   req_valid      per-requester send request, held until its req_ready pulse
//   req_data       request bytes, requester i on bits [8i+7:8i]
//   req_ready      one-cycle acceptance pulse, one-hot or zero
//   cfg_wr         write strobe for a new bit period
//   cfg_cpb        new cycles-per-bit value (zero writes are ignored)
//   cfg_pending    a written bit period is waiting to be applied
//   tx_en          start-of-frame strobe to the transmitter
//   tx_data        byte for the transmitter, held until the next grant
//   tx_busy        transmitter busy flag
//   cycles_per_bit bit period driven into the transmitter
//   grant_id       index of the most recently granted requester
//   active         high whenever the FSM is not in IDLE
//
// All outputs are registered; no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int RESET_CPB = 104
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [8*N_REQ-1:0]       req_data,
    output logic [N_REQ-1:0]         req_ready,
    input  logic                     cfg_wr,
    input  logic [15:0]              cfg_cpb,
    output logic                     cfg_pending,
    output logic                     tx_en,
    output logic [7:0]               tx_data,
    input  logic                     tx_busy,
    output logic [15:0]              cycles_per_bit,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     active
);

    localparam int GW = $clog2(N_REQ);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3
    } state_t;

    state_t        state;
    logic [15:0]   cpb_hold;
    logic          cfg_load;
    logic          win_found;
    logic [GW-1:0] win_idx;
    logic [7:0]    win_byte;

    assign cfg_load = cfg_wr && (cfg_cpb != 16'd0);

    // Round-robin search starting just after the last grant. grant_id doubles
    // as the last-grant pointer, so it must only move when a grant is made.
    always_comb begin
        logic [GW-1:0] cand_idx;
        cand_idx  = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand_idx = GW'((int'(grant_id) + k) % N_REQ);
            if (!win_found && req_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        win_byte = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == GW'(i)) begin
                win_byte = req_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= IDLE;
            tx_en          <= 1'b0;
            tx_data        <= 8'h00;
            req_ready      <= '0;
            cycles_per_bit <= 16'(RESET_CPB);
            cpb_hold       <= 16'd0;
            cfg_pending    <= 1'b0;
            grant_id       <= GW'(N_REQ - 1);
            active         <= 1'b0;
        end else begin
            tx_en     <= 1'b0;
            req_ready <= '0;

            case (state)
                IDLE: begin
                    // A pending bit period takes priority over arbitration so
                    // it lands before the next frame starts.
                    if (cfg_pending) begin
                        cycles_per_bit <= cpb_hold;
                        cfg_pending    <= 1'b0;
                    end else if (win_found) begin
                        state     <= ISSUE;
                        tx_en     <= 1'b1;
                        req_ready <= N_REQ'(1) << win_idx;
                        tx_data   <= win_byte;
                        grant_id  <= win_idx;
                        active    <= 1'b1;
                    end
                end
                ISSUE: begin
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state  <= IDLE;
                        active <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    active <= 1'b0;
                end
            endcase

            // Placed after the apply so a write in the apply cycle wins and
            // stays pending for the following IDLE cycle.
            if (cfg_load) begin
                cpb_hold    <= cfg_cpb;
                cfg_pending <= 1'b1;
            end
        end
    end

endmodule
